abs_diff_i4_o3: RTL and testbench

ABS_DIFF_I4_O3 -- requirements
Module: abs_diff_i4_o3

---
 rtl/abs_diff_pkg.sv | 18 +
 rtl/abs_diff_core.sv | 23 ++
 rtl/abs_diff_i4_o3.sv | 98 +++++++++
 tb/tb_abs_diff_i4_o3.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/abs_diff_pkg.sv
// Shared types for the 2-bit absolute-difference pipeline.
package abs_diff_pkg;

  localparam int OPERAND_W = 2;
  localparam int RESULT_W  = 2;

  typedef logic [OPERAND_W-1:0] operand_t;
  typedef logic [RESULT_W-1:0]  result_t;

  // One pipeline slot: the result travels together with its comparison flags.
  typedef struct packed {
    logic    valid;
    result_t result;
    logic    eq;
    logic    a_gt_b;
  } stage_t;

endpackage

// File: rtl/abs_diff_core.sv
// Combinational |A-B| with equality and greater-than flags.
module abs_diff_core
  import abs_diff_pkg::*;
(
  input  logic [OPERAND_W-1:0] a,
  input  logic [OPERAND_W-1:0] b,
  output logic [RESULT_W-1:0]  diff,
  output logic                 eq,
  output logic                 a_gt_b
);

  // Subtract the smaller operand from the larger so the result never wraps.
  always_comb begin
    eq     = (a == b);
    a_gt_b = (a > b);
    if (a_gt_b) begin
      diff = a - b;
    end else begin
      diff = b - a;
    end
  end

endmodule

// File: rtl/abs_diff_i4_o3.sv
// Pipelined |A-B| of two 2-bit operands, result LATENCY cycles after acceptance.
// Defining ABS_DIFF_FLAGS_EN adds the eq / a_gt_b output ports.
module abs_diff_i4_o3
  import abs_diff_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic pi0,
  input  logic pi1,
  input  logic pi2,
  input  logic pi3,
  output logic po0,
  output logic po1,
  output logic out_valid
`ifdef ABS_DIFF_FLAGS_EN
  ,
  output logic eq,
  output logic a_gt_b
`endif
);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("abs_diff_i4_o3: LATENCY must be in 1..4");
  end

  logic     smp_valid_r;
  operand_t smp_a_r;
  operand_t smp_b_r;

  result_t  core_diff_s;
  logic     core_eq_s;
  logic     core_gt_s;

  stage_t   stage_r     [LATENCY];
  stage_t   stage_in_s  [LATENCY];
  stage_t   stage_nxt_s [LATENCY];

  abs_diff_core u_core (
    .a      (smp_a_r),
    .b      (smp_b_r),
    .diff   (core_diff_s),
    .eq     (core_eq_s),
    .a_gt_b (core_gt_s)
  );

  // Stage feed and next-state; the last stage keeps its payload across bubbles.
  always_comb begin
    stage_in_s[0] = '{valid: smp_valid_r, result: core_diff_s,
                      eq: core_eq_s, a_gt_b: core_gt_s};
    for (int i = 1; i < LATENCY; i++) begin
      stage_in_s[i] = stage_r[i-1];
    end
    for (int i = 0; i < LATENCY; i++) begin
      stage_nxt_s[i] = stage_in_s[i];
    end
    if (stage_in_s[LATENCY-1].valid) begin
      stage_nxt_s[LATENCY-1] = stage_in_s[LATENCY-1];
    end else begin
      stage_nxt_s[LATENCY-1]       = stage_r[LATENCY-1];
      stage_nxt_s[LATENCY-1].valid = 1'b0;
    end
  end

  // Sample register and stage pipeline; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_valid_r <= 1'b0;
      smp_a_r     <= '0;
      smp_b_r     <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      smp_valid_r <= in_valid;
      smp_a_r     <= {pi1, pi0};
      smp_b_r     <= {pi3, pi2};
      for (int i = 0; i < LATENCY; i++) begin
        stage_r[i] <= stage_nxt_s[i];
      end
    end
  end

  assign po0       = stage_r[LATENCY-1].result[0];
  assign po1       = stage_r[LATENCY-1].result[1];
  assign out_valid = stage_r[LATENCY-1].valid;

`ifdef ABS_DIFF_FLAGS_EN
  assign eq     = stage_r[LATENCY-1].eq;
  assign a_gt_b = stage_r[LATENCY-1].a_gt_b;
`else
  logic unused_flags_s;
  assign unused_flags_s = stage_r[LATENCY-1].eq ^ stage_r[LATENCY-1].a_gt_b;
`endif

endmodule

// File: tb/tb_abs_diff_i4_o3.sv
// Scoreboard bench: four DUTs (LATENCY 1..4) share one directed stimulus stream.
module tb_abs_diff_i4_o3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic pi0 = 1'b0, pi1 = 1'b0, pi2 = 1'b0, pi3 = 1'b0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due_base;
    logic [1:0] res;
    logic       eq;
    logic       gt;
  } exp_t;

  exp_t exp_q[$];
  int   last_rst_cyc = 1;
  int   checks = 0;
  int   failures = 0;

  for (genvar g = 0; g < 4; g++) begin : lane
    localparam int L = g + 1;
    logic po0_s, po1_s, ov_s;
`ifdef ABS_DIFF_FLAGS_EN
    logic eq_s, gt_s;
`endif
    abs_diff_i4_o3 #(.LATENCY(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .pi0       (pi0),
      .pi1       (pi1),
      .pi2       (pi2),
      .pi3       (pi3),
      .po0       (po0_s),
      .po1       (po1_s),
      .out_valid (ov_s)
`ifdef ABS_DIFF_FLAGS_EN
      ,
      .eq        (eq_s),
      .a_gt_b    (gt_s)
`endif
    );

    int         rd = 0;
    logic [1:0] last_res = 2'b00;
    logic       last_eq = 1'b0;
    logic       last_gt = 1'b0;

    always @(negedge clk) begin
      logic exp_v;
      exp_v = 1'b0;
      if (cyc >= 1) begin
        if (cyc == last_rst_cyc) begin
          last_res = 2'b00;
          last_eq  = 1'b0;
          last_gt  = 1'b0;
        end
        while (rd < exp_q.size() && exp_q[rd].due_base < last_rst_cyc &&
               exp_q[rd].due_base + L >= last_rst_cyc) begin
          rd++;
        end
        if (rd < exp_q.size() && exp_q[rd].due_base + L == cyc) begin
          exp_v    = 1'b1;
          last_res = exp_q[rd].res;
          last_eq  = exp_q[rd].eq;
          last_gt  = exp_q[rd].gt;
          rd++;
        end
        checks++;
        assert (ov_s === exp_v) else begin
          failures++;
          $error("FAIL lat%0d_out_valid cyc=%0d observed=%b expected=%b", L, cyc, ov_s, exp_v);
        end
        checks++;
        assert ({po1_s, po0_s} === last_res) else begin
          failures++;
          $error("FAIL lat%0d_po cyc=%0d observed=%b expected=%b", L, cyc, {po1_s, po0_s}, last_res);
        end
`ifdef ABS_DIFF_FLAGS_EN
        checks++;
        assert ({eq_s, gt_s} === {last_eq, last_gt}) else begin
          failures++;
          $error("FAIL lat%0d_flags cyc=%0d observed=%b expected=%b", L, cyc, {eq_s, gt_s}, {last_eq, last_gt});
        end
`endif
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic [3:0] nib);
    int a, b, d;
    exp_t e;
    @(negedge clk);
    #1;
    rst = r;
    in_valid = v;
    {pi3, pi2, pi1, pi0} = nib;
    if (r) begin
      last_rst_cyc = cyc + 1;
    end else if (v) begin
      a = int'(nib[1:0]);
      b = int'(nib[3:2]);
      d = a - b;
      if (d < 0) d = -d;
      e.due_base = cyc + 1;
      e.res = d[1:0];
      e.eq  = (a == b);
      e.gt  = (a > b);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_drained(input int idx, input int rd_val);
    checks++;
    assert (rd_val === exp_q.size()) else begin
      failures++;
      $error("FAIL lat%0d_drain observed=%0d expected=%0d", idx + 1, rd_val, exp_q.size());
    end
  endtask

  initial begin
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    // exhaustive sweep, back to back
    for (int n = 0; n < 16; n++) step(1'b0, 1'b1, 4'(n));
    for (int n = 0; n < 5; n++) step(1'b0, 1'b0, 4'h0);
    // bubble pattern: result must hold through the gap
    step(1'b0, 1'b1, 4'b0001);
    step(1'b0, 1'b0, 4'b1111);
    step(1'b0, 1'b1, 4'b1000);
    for (int n = 0; n < 5; n++) step(1'b0, 1'b0, 4'h0);
    // reset with a sample in flight; in_valid high during reset is ignored
    step(1'b0, 1'b1, 4'b0011);
    step(1'b1, 1'b1, 4'b1100);
    step(1'b0, 1'b1, 4'b0100);
    for (int n = 0; n < 6; n++) step(1'b0, 1'b0, 4'h0);
    // flag cases
    step(1'b0, 1'b1, 4'b0101);
    step(1'b0, 1'b1, 4'b0110);
    step(1'b0, 1'b1, 4'b1001);
    step(1'b0, 1'b0, 4'h0);
    // random mix of valid and idle cycles
    for (int n = 0; n < 24; n++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    for (int n = 0; n < 6; n++) step(1'b0, 1'b0, 4'h0);
    @(negedge clk);
    #1;
    check_drained(0, lane[0].rd);
    check_drained(1, lane[1].rd);
    check_drained(2, lane[2].rd);
    check_drained(3, lane[3].rd);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
